// File: rtl/exc_pkg.sv
// Shared definitions for the exception/interrupt arbiter: cause codes,
// arbiter state encoding and CP0 status bit positions.
package exc_pkg;

  // Cause codes handed to CP0
  localparam logic [4:0] CAUSE_INT = 5'b00000;
  localparam logic [4:0] CAUSE_SYS = 5'b01000;
  localparam logic [4:0] CAUSE_BRK = 5'b01001;
  localparam logic [4:0] CAUSE_TEQ = 5'b01101;

  // Arbiter states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HANDLER = 2'd2,
    ST_RETURN  = 2'd3
  } state_t;

  // CP0 status word bit positions
  localparam int STATUS_IE       = 0;
  localparam int STATUS_IM_BASE  = 8;
  localparam int STATUS_TIMER_IM = 15;

endpackage

// File: rtl/exc_arbiter_irq_sync.sv
// irq_sync: multi-stage synchroniser for asynchronous interrupt lines
// followed by a rising-edge detector. rise is a one-cycle pulse per edge.
module irq_sync #(
  parameter int W      = 6,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] rise
);

  logic [STAGES-1:0][W-1:0] sync_q, sync_d;
  logic [W-1:0]             prev_q, prev_d;

  // Shift the raw lines through the synchroniser chain
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d_in;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[STAGES-1];
  end

  // Synchroniser and edge-history registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/exc_arbiter.sv
// exc_arbiter: merges decode traps, eret and external interrupts into a
// single exception/eret/cause/pc stream for CP0, refusing nested traps.
// Optional feature macro TIMER_EN adds a count/compare timer interrupt.
// Handshake: exception/eret are one-cycle registered pulses; cause and pc
// are valid whenever exception is high and hold until the next issue.
module exc_arbiter
  import exc_pkg::*;
#(
  parameter int NUM_IRQ     = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [31:0]        status,
  input  logic               syscall,
  input  logic               brk,
  input  logic               teq,
  input  logic               teq_eq,
  input  logic               eret_in,
  input  logic [31:0]        inst_pc,
  input  logic               stall,
  output logic               exception,
  output logic               eret,
  output logic [4:0]         cause,
  output logic [31:0]        pc,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               in_handler,
  output logic               double_fault,
  output logic [1:0]         dbg_state
`ifdef TIMER_EN
  ,
  input  logic               cmp_we,
  input  logic [31:0]        cmp_wdata,
  output logic               timer_int
`endif
);

  state_t             state_q, state_d;
  logic               exception_q, exception_d;
  logic               eret_q, eret_d;
  logic [4:0]         cause_q, cause_d;
  logic [31:0]        pc_q, pc_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic               in_handler_q, in_handler_d;
  logic               dfault_q, dfault_d;

  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] irq_elig;
  logic [NUM_IRQ-1:0] irq_win;
  logic               trap;
  logic               take_int;
  logic               idle_go;
  logic               ret_go;

  irq_sync #(
    .W      (NUM_IRQ),
    .STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .clk  (clk),
    .rst  (rst),
    .d_in (irq_in),
    .rise (irq_rise)
  );

  assign trap     = syscall | brk | (teq & teq_eq);
  assign irq_elig = pend_q & status[STATUS_IM_BASE +: NUM_IRQ] & {NUM_IRQ{status[STATUS_IE]}};
  // Isolate the lowest-indexed eligible line
  assign irq_win  = irq_elig & (~irq_elig + 1'b1);

`ifdef TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic        tpend_q, tpend_d;
  logic        timer_elig;

  assign timer_elig = tpend_q & status[STATUS_TIMER_IM] & status[STATUS_IE];
  assign take_int   = (|irq_elig) | timer_elig;

  // Free-running count, compare register and timer pending bit
  always_comb begin
    count_d = count_q + 32'd1;
    cmp_d   = cmp_we ? cmp_wdata : cmp_q;
    tpend_d = tpend_q;
    if (idle_go && !trap && !(|irq_elig)) tpend_d = 1'b0;
    if (count_q == cmp_q)                 tpend_d = 1'b1;
    if (cmp_we)                           tpend_d = 1'b0;
  end

  // Timer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      tpend_q <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      tpend_q <= tpend_d;
    end
  end

  assign timer_int = tpend_q;
`else
  assign take_int = |irq_elig;
`endif

  assign idle_go = (state_q == ST_IDLE) && !stall && (trap || take_int);
  assign ret_go  = (state_q == ST_HANDLER) && !stall && eret_in;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; ISSUE and RETURN always complete in one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (idle_go) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_HANDLER;
      ST_HANDLER: if (ret_go) state_d = ST_RETURN;
      ST_RETURN:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values: pulses, cause/pc latch, pending bits
  always_comb begin
    exception_d  = idle_go | ret_go;
    eret_d       = ret_go;
    in_handler_d = (state_d == ST_HANDLER);
    cause_d      = cause_q;
    pc_d         = pc_q;
    dfault_d     = dfault_q | ((state_q == ST_HANDLER) && !stall && trap);
    pend_d       = pend_q;
    if (idle_go) begin
      pc_d = inst_pc;
      if (syscall)           cause_d = CAUSE_SYS;
      else if (brk)          cause_d = CAUSE_BRK;
      else if (teq & teq_eq) cause_d = CAUSE_TEQ;
      else begin
        cause_d = CAUSE_INT;
        pend_d  = pend_q & ~irq_win;
      end
    end
    // A new edge on the clearing cycle keeps the bit set
    pend_d = pend_d | irq_rise;
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exception_q  <= 1'b0;
      eret_q       <= 1'b0;
      cause_q      <= '0;
      pc_q         <= '0;
      pend_q       <= '0;
      in_handler_q <= 1'b0;
      dfault_q     <= 1'b0;
    end else begin
      exception_q  <= exception_d;
      eret_q       <= eret_d;
      cause_q      <= cause_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      in_handler_q <= in_handler_d;
      dfault_q     <= dfault_d;
    end
  end

  assign exception    = exception_q;
  assign eret         = eret_q;
  assign cause        = cause_q;
  assign pc           = pc_q;
  assign irq_pending  = pend_q;
  assign in_handler   = in_handler_q;
  assign double_fault = dfault_q;
  assign dbg_state    = state_q;

endmodule
